// File: rtl/stack_seq.sv
// stack_seq: Game Boy PUSH/POP sequencer moving a register pair to or from the stack over a req/ack bus.
// Optional STACK_SEQ_WRAP_ERR_EN adds a sticky wrap_err flag for SP wrap-around.
module stack_seq #(
    parameter logic [2:0] SP_HI_IDX = 3'd6,
    parameter logic [2:0] SP_LO_IDX = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_pop,
    input  logic [1:0]  pair,
    output logic        busy,
    output logic        done,
    output logic [1:0]  rf_rdwn,
    input  logic [15:0] rf_rdw,
    input  logic [15:0] rf_sp,
    output logic [2:0]  rf_wrn,
    output logic [7:0]  rf_wr,
    output logic        rf_we,
    input  logic [7:0]  a_in,
    input  logic [7:0]  f_in,
    output logic        a_we,
    output logic        f_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_req,
    output logic        mem_wr,
    input  logic [7:0]  mem_rdata,
`ifdef STACK_SEQ_WRAP_ERR_EN
    output logic        wrap_err,
`endif
    input  logic        mem_ack
);
    typedef enum logic [3:0] {
        IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, WR_H, WR_L, SP_H, SP_L, DONE
    } state_t;
    state_t state;
    logic [1:0] pr;
    logic [15:0] sp, data;
    logic [15:0] push_data, sp_dec, sp_dec2, sp_inc;
    assign rf_rdwn = pair;
    assign push_data = (pair == 2'd3) ? {a_in, f_in} : rf_rdw;
    assign sp_dec = sp - 16'd1;
    assign sp_dec2 = sp - 16'd2;
    assign sp_inc = sp + 16'd1;
    // Outputs are registered: each transition loads the strobes for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pr <= 2'd0;
            sp <= 16'd0;
            data <= 16'd0;
            busy <= 1'b0;
            done <= 1'b0;
            mem_req <= 1'b0;
            mem_wr <= 1'b0;
            mem_addr <= 16'd0;
            mem_wdata <= 8'd0;
            rf_we <= 1'b0;
            a_we <= 1'b0;
            f_we <= 1'b0;
            rf_wr <= 8'd0;
            rf_wrn <= 3'd0;
`ifdef STACK_SEQ_WRAP_ERR_EN
            wrap_err <= 1'b0;
`endif
        end else begin
            rf_we <= 1'b0;
            a_we <= 1'b0;
            f_we <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    pr <= pair;
                    sp <= rf_sp;
                    data <= push_data;
                    busy <= 1'b1;
                    mem_req <= 1'b1;
                    mem_wr <= !op_pop;
                    mem_addr <= op_pop ? rf_sp : rf_sp - 16'd1;
                    mem_wdata <= op_pop ? 8'd0 : push_data[15:8];
                    state <= op_pop ? POP_LO : PUSH_HI;
`ifdef STACK_SEQ_WRAP_ERR_EN
                    wrap_err <= 1'b0;
`endif
                end
                PUSH_HI: if (mem_ack) begin
                    sp <= sp_dec;
                    mem_addr <= sp_dec2;
                    mem_wdata <= data[7:0];
                    state <= PUSH_LO;
`ifdef STACK_SEQ_WRAP_ERR_EN
                    if (sp == 16'h0000) wrap_err <= 1'b1;
`endif
                end
                PUSH_LO: if (mem_ack) begin
                    sp <= sp_dec;
                    mem_req <= 1'b0;
                    mem_wr <= 1'b0;
                    rf_we <= 1'b1;
                    rf_wrn <= SP_HI_IDX;
                    rf_wr <= sp_dec[15:8];
                    state <= SP_H;
`ifdef STACK_SEQ_WRAP_ERR_EN
                    if (sp == 16'h0000) wrap_err <= 1'b1;
`endif
                end
                POP_LO: if (mem_ack) begin
                    data[7:0] <= mem_rdata;
                    sp <= sp_inc;
                    mem_addr <= sp_inc;
                    state <= POP_HI;
`ifdef STACK_SEQ_WRAP_ERR_EN
                    if (sp == 16'hFFFF) wrap_err <= 1'b1;
`endif
                end
                POP_HI: if (mem_ack) begin
                    data[15:8] <= mem_rdata;
                    sp <= sp_inc;
                    mem_req <= 1'b0;
                    rf_we <= (pr != 2'd3);
                    a_we <= (pr == 2'd3);
                    rf_wrn <= (pr != 2'd3) ? {pr, 1'b0} : rf_wrn;
                    rf_wr <= mem_rdata;
                    state <= WR_H;
`ifdef STACK_SEQ_WRAP_ERR_EN
                    if (sp == 16'hFFFF) wrap_err <= 1'b1;
`endif
                end
                WR_H: begin
                    rf_we <= (pr != 2'd3);
                    f_we <= (pr == 2'd3);
                    rf_wrn <= (pr != 2'd3) ? {pr, 1'b1} : rf_wrn;
                    rf_wr <= (pr != 2'd3) ? data[7:0] : {data[7:4], 4'b0000};
                    state <= WR_L;
                end
                WR_L: begin
                    rf_we <= 1'b1;
                    rf_wrn <= SP_HI_IDX;
                    rf_wr <= sp[15:8];
                    state <= SP_H;
                end
                SP_H: begin
                    rf_we <= 1'b1;
                    rf_wrn <= SP_LO_IDX;
                    rf_wr <= sp[7:0];
                    state <= SP_L;
                end
                SP_L: begin
                    done <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy <= 1'b0;
                    mem_req <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq: directed PUSH/POP sequences with hand-computed bus and regfile traffic.
module tb_stack_seq;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, op_pop = 1'b0;
    logic [1:0] pair = 2'd0, rf_rdwn;
    logic busy, done, rf_we, a_we, f_we, mem_req, mem_wr;
    logic [15:0] rf_rdw = 16'd0, rf_sp = 16'd0, mem_addr;
    logic [2:0] rf_wrn;
    logic [7:0] rf_wr, mem_wdata, a_in = 8'd0, f_in = 8'd0, mem_rdata = 8'd0;
    logic mem_ack = 1'b0;
`ifdef STACK_SEQ_WRAP_ERR_EN
    logic wrap_err;
`endif
    int errors = 0, checks = 0, done_cnt = 0, d0;

    stack_seq dut (
        .clk(clk), .rst(rst), .start(start), .op_pop(op_pop), .pair(pair),
        .busy(busy), .done(done), .rf_rdwn(rf_rdwn), .rf_rdw(rf_rdw), .rf_sp(rf_sp),
        .rf_wrn(rf_wrn), .rf_wr(rf_wr), .rf_we(rf_we), .a_in(a_in), .f_in(f_in),
        .a_we(a_we), .f_we(f_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
`ifdef STACK_SEQ_WRAP_ERR_EN
        .wrap_err(wrap_err),
`endif
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(); step();
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_req", mem_req, 0);
        chk("rst_wr", mem_wr, 0); chk("rst_we", {rf_we, a_we, f_we}, 0);
        chk("rst_addr", mem_addr, 0); chk("rst_wrn", rf_wrn, 0); chk("rst_wdata", mem_wdata, 0);
        pair = 2'd2; #1; chk("rdwn_follow", rf_rdwn, 2);
        rst = 1'b0;
        // PUSH BC, SP=FFFE, immediate ack
        pair = 2'd0; rf_rdw = 16'h1234; rf_sp = 16'hFFFE; op_pop = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        chk("p1_hi_req", {busy, mem_req, mem_wr}, 3'b111);
        chk("p1_hi_addr", mem_addr, 16'hFFFD); chk("p1_hi_wd", mem_wdata, 8'h12);
        mem_ack = 1'b1; step();
        chk("p1_lo_req", mem_req, 1); chk("p1_lo_addr", mem_addr, 16'hFFFC); chk("p1_lo_wd", mem_wdata, 8'h34);
        step(); mem_ack = 1'b0;
        chk("p1_sph", {mem_req, rf_we, rf_wrn, rf_wr}, {1'b0, 1'b1, 3'd6, 8'hFF});
        step(); chk("p1_spl", {rf_we, rf_wrn, rf_wr}, {1'b1, 3'd7, 8'hFC});
        step(); chk("p1_done", {busy, done, rf_we}, 3'b110);
        step(); chk("p1_idle", {busy, done}, 2'b00);
        // POP HL, SP=C000, two wait cycles per byte
        pair = 2'd2; op_pop = 1'b1; rf_sp = 16'hC000; start = 1'b1;
        step(); start = 1'b0;
        chk("p2_lo", {mem_req, mem_wr, mem_addr}, {2'b10, 16'hC000});
        step(); chk("p2_lo_w1", {mem_req, mem_addr}, {1'b1, 16'hC000});
        step(); chk("p2_lo_w2", {mem_req, mem_addr}, {1'b1, 16'hC000});
        mem_ack = 1'b1; mem_rdata = 8'h78; step(); mem_ack = 1'b0;
        chk("p2_hi", {mem_req, mem_wr, mem_addr}, {2'b10, 16'hC001});
        step(); step(); chk("p2_hi_w2", {mem_req, mem_addr}, {1'b1, 16'hC001});
        mem_ack = 1'b1; mem_rdata = 8'h56; step(); mem_ack = 1'b0;
        chk("p2_wrh", {mem_req, rf_we, a_we, rf_wrn, rf_wr}, {3'b010, 3'd4, 8'h56});
        step(); chk("p2_wrl", {rf_we, f_we, rf_wrn, rf_wr}, {2'b10, 3'd5, 8'h78});
        step(); chk("p2_sph", {rf_we, rf_wrn, rf_wr}, {1'b1, 3'd6, 8'hC0});
        step(); chk("p2_spl", {rf_we, rf_wrn, rf_wr}, {1'b1, 3'd7, 8'h02});
        step(); chk("p2_done", {busy, done}, 2'b11);
        step(); chk("p2_idle", busy, 0);
        // POP AF, SP=D000: A=AB, F low nibble masked
        pair = 2'd3; op_pop = 1'b1; rf_sp = 16'hD000; start = 1'b1;
        step(); start = 1'b0;
        chk("p3_lo_addr", mem_addr, 16'hD000);
        mem_ack = 1'b1; mem_rdata = 8'hFF; step();
        chk("p3_hi_addr", mem_addr, 16'hD001);
        mem_rdata = 8'hAB; step(); mem_ack = 1'b0;
        chk("p3_wrh", {rf_we, a_we, f_we, rf_wr}, {3'b010, 8'hAB});
        step(); chk("p3_wrl", {rf_we, a_we, f_we, rf_wr}, {3'b001, 8'hF0});
        step(); chk("p3_sph", {rf_we, a_we, f_we, rf_wrn, rf_wr}, {3'b100, 3'd6, 8'hD0});
        step(); chk("p3_spl", {rf_we, rf_wrn, rf_wr}, {1'b1, 3'd7, 8'h02});
        step(); step(); chk("p3_idle", busy, 0);
        // PUSH AF, SP=0001 wraps through 0000 to FFFF
        pair = 2'd3; op_pop = 1'b0; a_in = 8'h01; f_in = 8'hB0; rf_rdw = 16'hDEAD; rf_sp = 16'h0001; start = 1'b1;
        step(); start = 1'b0;
        chk("p4_hi", {mem_addr, mem_wdata}, {16'h0000, 8'h01});
        mem_ack = 1'b1; step();
        chk("p4_lo", {mem_addr, mem_wdata}, {16'hFFFF, 8'hB0});
        step(); mem_ack = 1'b0;
        chk("p4_sph", {rf_we, rf_wrn, rf_wr}, {1'b1, 3'd6, 8'hFF});
        step(); chk("p4_spl", {rf_we, rf_wrn, rf_wr}, {1'b1, 3'd7, 8'hFF});
        step(); chk("p4_done", done, 1);
`ifdef STACK_SEQ_WRAP_ERR_EN
        chk("p4_wrap", wrap_err, 1);
`endif
        step();
        // Reset while PUSH_LO holds mem_req
        d0 = done_cnt;
        pair = 2'd1; rf_rdw = 16'hABCD; rf_sp = 16'h1000; start = 1'b1;
        step(); mem_ack = 1'b1; step();
        chk("p5_lo", {mem_req, mem_addr, mem_wdata}, {1'b1, 16'h0FFE, 8'hCD});
        rst = 1'b1; mem_ack = 1'b0; step();
        chk("p5_abort", {busy, mem_req, rf_we, done}, 4'b0000);
`ifdef STACK_SEQ_WRAP_ERR_EN
        chk("p5_wrap_rst", wrap_err, 0);
`endif
        rst = 1'b0; start = 1'b0; step();
        chk("p5_quiet", {busy, mem_req, rf_we}, 3'b000);
        // POP DE with start held throughout and ack asserted in every cycle
        pair = 2'd1; op_pop = 1'b1; rf_sp = 16'h2000; mem_rdata = 8'h11; start = 1'b1; mem_ack = 1'b1;
        step(); chk("p6_lo", {mem_req, mem_addr}, {1'b1, 16'h2000});
        step(); step(); chk("p6_wrh", {rf_we, rf_wrn, rf_wr}, {1'b1, 3'd2, 8'h11});
        step(); step(); step(); chk("p6_nodone", done, 0);
        step(); chk("p6_done", {busy, done}, 2'b11);
        start = 1'b0; mem_ack = 1'b0;
        step(); chk("p6_idle", {busy, mem_req}, 2'b00);
        step(); step();
        chk("done_count", done_cnt - d0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
